alu_result_mux_pipe: RTL and testbench

Parametrised, registered W-bit N:1 result selector for the ALU output stage, the pipelined successor to the 1-bit 8:1 mux. Each accepted transfer selects one of 2^SEL_BITS operation results with `in_sel` and registers the chosen word together with a zero flag. The result goes out through a valid/ready handshake backed by a 2-entry skid buffer, so the ALU front end and the consumer decouple without combinational ready paths. It sits between the per-operation datapaths (AND, OR, ADD, SUB, ...) and the register-file writeback.

---
 rtl/alu_result_mux_pipe.sv | 147 ++++++++++++++
 tb/tb_alu_result_mux_pipe.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_mux_pipe.sv
// rtl/alu_result_mux_pipe.sv - registered N:1 ALU result selector with 2-entry skid buffer
//
// Purpose: on each accepted transfer, pick one of 2**SEL_BITS channel results,
// tag it with its select and a zero flag, and hand it to the consumer through
// a valid/ready handshake. The main/skid pair lets the producer and consumer
// decouple without any combinational ready path.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   in_valid   in   producer offers a set of channel results
//   in_ready   out  block can accept this cycle
//   in_data    in   WIDTH*NUM_IN flattened channels, channel k at [k*WIDTH +: WIDTH]
//   in_sel     in   channel index to select
//   out_valid  out  out_data/out_sel/out_zero hold a valid result
//   out_ready  in   consumer takes the result this cycle
//   out_data   out  selected channel value
//   out_sel    out  select that produced out_data
//   out_zero   out  1 when out_data is zero (registered with its entry)
module alu_result_mux_pipe #(
  parameter int WIDTH    = 32,
  parameter int SEL_BITS = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH*(2**SEL_BITS)-1:0]  in_data,
  input  logic [SEL_BITS-1:0]             in_sel,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH-1:0]                out_data,
  output logic [SEL_BITS-1:0]             out_sel,
  output logic                            out_zero
);

  localparam int NUM_IN = 2 ** SEL_BITS;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      main_data_q, main_data_d;
  logic [SEL_BITS-1:0]   main_sel_q, main_sel_d;
  logic                  main_zero_q, main_zero_d;
  logic [WIDTH-1:0]      skid_data_q, skid_data_d;
  logic [SEL_BITS-1:0]   skid_sel_q, skid_sel_d;
  logic                  skid_zero_q, skid_zero_d;

  logic [WIDTH-1:0]      new_data;
  logic                  new_zero;
  logic                  accept;
  logic                  out_xfer;

  // Full decode of the select: every in_sel value maps to exactly one channel.
  always_comb begin
    new_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_BITS'(k)) begin
        new_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign new_zero = (new_data == '0);

  // Ready depends only on registered state and reset, never on out_ready.
  assign in_ready  = (state_q != ST_FULL) && !reset;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_data_q;
  assign out_sel   = main_sel_q;
  assign out_zero  = main_zero_q;

  assign accept   = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    main_zero_d = main_zero_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    skid_zero_d = skid_zero_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_data_d = new_data;
          main_sel_d  = in_sel;
          main_zero_d = new_zero;
          state_d     = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && out_xfer) begin
          // Head leaves as the new entry arrives: new entry goes straight to main.
          main_data_d = new_data;
          main_sel_d  = in_sel;
          main_zero_d = new_zero;
        end else if (accept) begin
          skid_data_d = new_data;
          skid_sel_d  = in_sel;
          skid_zero_d = new_zero;
          state_d     = ST_FULL;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          main_data_d = skid_data_q;
          main_sel_d  = skid_sel_q;
          main_zero_d = skid_zero_q;
          state_d     = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_sel_q  <= '0;
      main_zero_q <= 1'b0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      skid_zero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
      main_zero_q <= main_zero_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      skid_zero_q <= skid_zero_d;
    end
  end

endmodule

// File: tb/tb_alu_result_mux_pipe.sv
// tb/tb_alu_result_mux_pipe.sv - self-checking bench for alu_result_mux_pipe
module tb_alu_result_mux_pipe;

  localparam int WIDTH    = 32;
  localparam int SEL_BITS = 3;
  localparam int NUM_IN   = 8;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       in_valid;
  logic                       in_ready;
  logic [WIDTH*NUM_IN-1:0]    in_data;
  logic [SEL_BITS-1:0]        in_sel;
  logic                       out_valid;
  logic                       out_ready;
  logic [WIDTH-1:0]           out_data;
  logic [SEL_BITS-1:0]        out_sel;
  logic                       out_zero;

  logic [WIDTH-1:0]           chan [NUM_IN];

  typedef struct {
    logic [WIDTH-1:0]    data;
    logic [SEL_BITS-1:0] sel;
  } entry_t;

  // Reference model: a 2-deep FIFO of selected results.
  entry_t q[$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NUM_IN; k++) begin
      in_data[k*WIDTH +: WIDTH] = chan[k];
    end
  end

  alu_result_mux_pipe #(.WIDTH(WIDTH), .SEL_BITS(SEL_BITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_zero  (out_zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check in_ready against the model, advance model and DUT, then
  // check the outputs against the head of the model FIFO.
  task automatic step();
    bit     acc;
    bit     xfer;
    bit     exp_rdy;
    entry_t e;
    #1;
    exp_rdy = (q.size() < 2) && !reset;
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    acc  = in_valid && exp_rdy;
    xfer = (q.size() > 0) && out_ready;
    e.data = chan[in_sel];
    e.sel  = in_sel;
    @(posedge clk);
    if (reset) begin
      q.delete();
    end else begin
      if (xfer) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    #1;
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      check("out_data", 64'(out_data), 64'(q[0].data));
      check("out_sel", 64'(out_sel), 64'(q[0].sel));
      check("out_zero", 64'(out_zero), 64'(q[0].data == 0));
    end
  endtask

  initial begin
    logic [WIDTH-1:0] val_a;
    logic [WIDTH-1:0] val_b;
    logic [WIDTH-1:0] val_d;

    // Reset and basic select; in_valid during reset must be ignored.
    for (int k = 0; k < NUM_IN; k++) chan[k] = 32'h1000_0000 + k;
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_sel    = 3'd5;
    out_ready = 1'b1;
    step();
    step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_sel", 64'(out_sel), 64'd0);
    check("rst_out_zero", 64'(out_zero), 64'd0);
    reset = 1'b0;
    step();
    check("basic_valid", 64'(out_valid), 64'd1);
    check("basic_data", 64'(out_data), 64'h1000_0005);
    check("basic_sel", 64'(out_sel), 64'd5);
    check("basic_zero", 64'(out_zero), 64'd0);

    // Zero flag and boundary selects.
    chan[0] = 32'h0;
    chan[7] = 32'hFFFF_FFFF;
    in_sel  = 3'd0;
    step();
    check("sel0_data", 64'(out_data), 64'd0);
    check("sel0_zero", 64'(out_zero), 64'd1);
    in_sel = 3'd7;
    step();
    check("sel7_data", 64'(out_data), 64'hFFFF_FFFF);
    check("sel7_zero", 64'(out_zero), 64'd0);
    in_valid = 1'b0;
    step();

    // Backpressure fill: A, B accepted, C held off.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    chan[1] = 32'hAAAA_0001; chan[2] = 32'hBBBB_0002; chan[3] = 32'hCCCC_0003;
    in_sel = 3'd1;
    step();
    in_sel = 3'd2;
    step();
    check("full_in_ready", 64'(in_ready), 64'd0);
    in_sel = 3'd3;
    step();
    step();
    check("hold_data", 64'(out_data), 64'hAAAA_0001);
    check("hold_sel", 64'(out_sel), 64'd1);
    check("hold_ready", 64'(in_ready), 64'd0);

    // Drain order: A, B, C on consecutive cycles; C accepted once a slot frees.
    out_ready = 1'b1;
    step();
    check("drain_b", 64'(out_data), 64'hBBBB_0002);
    check("drain_ready_back", 64'(in_ready), 64'd1);
    step();
    check("drain_c", 64'(out_data), 64'hCCCC_0003);
    in_valid = 1'b0;
    step();
    check("drain_empty", 64'(out_valid), 64'd0);

    // Streaming: 16 back-to-back random transfers.
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < NUM_IN; k++) chan[k] = $urandom;
      in_sel = SEL_BITS'($urandom_range(0, NUM_IN - 1));
      step();
      check("stream_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    step();

    // Mid-operation reset from FULL, then a lone D.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    val_a = $urandom; val_b = $urandom; val_d = $urandom | 32'h1;
    chan[4] = val_a; in_sel = 3'd4;
    step();
    chan[6] = val_b; in_sel = 3'd6;
    step();
    check("pre_rst_ready", 64'(in_ready), 64'd0);
    reset = 1'b1;
    step();
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_data", 64'(out_data), 64'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    chan[2] = val_d; in_sel = 3'd2;
    step();
    check("d_valid", 64'(out_valid), 64'd1);
    check("d_data", 64'(out_data), 64'(val_d));
    check("d_sel", 64'(out_sel), 64'd2);
    in_valid = 1'b0;
    step();
    check("d_alone", 64'(out_valid), 64'd0);

    // Random traffic with random backpressure and an occasional reset.
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < NUM_IN; k++) chan[k] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      in_sel    = SEL_BITS'($urandom_range(0, NUM_IN - 1));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      reset     = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
